// File: rtl/loop_nest_seq_pkg.sv
// Shared types and width helpers for loop_nest_sequencer.
//   state_e       : sequencer states (IDLE, RUN, DONE)
//   NumOuterWidth : width of the num_outer_i trip-count input
//   kw_of/lw_of/pw_of : derived widths of k, l and param for a given NumOuter
package loop_nest_seq_pkg;

  localparam int unsigned NumOuterWidth = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Outer index width: k never exceeds NumOuter-1.
  function automatic int unsigned kw_of(input int unsigned num_outer);
    return (num_outer <= 2) ? 1 : $clog2(num_outer);
  endfunction

  // Inner index width: l never exceeds 2^(NumOuter-1)-1.
  function automatic int unsigned lw_of(input int unsigned num_outer);
    return (num_outer <= 1) ? 1 : num_outer - 1;
  endfunction

  // Param width: 2^k + l never exceeds 2^NumOuter-1.
  function automatic int unsigned pw_of(input int unsigned num_outer);
    return num_outer;
  endfunction

endpackage

// File: rtl/loop_nest_sequencer.sv
// Runtime sequencer for the triangular loop nest k = 0..n-1, l = 0..2^k-1.
// Emits one (k, l, 2^k + l) tuple per valid/ready handshake.
// Optional feature: define LOOP_NEST_SEQ_STATS_EN to add stall_cnt_o.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i           : start request, accepted only in IDLE
//   num_outer_i       : outer trip count n, clamped to NumOuter
//   abort_i           : abandon the current run (RUN only)
//   valid_o / ready_i : tuple stream handshake
//   k_o, l_o, param_o : tuple payload
//   last_o            : final tuple of the run
//   busy_o            : high in RUN and DONE
//   done_o            : one-cycle completion pulse
//   stall_cnt_o       : cycles with valid_o & ~ready_i (stats build only)
module loop_nest_sequencer
  import loop_nest_seq_pkg::*;
#(
  parameter int unsigned NumOuter = 3,
  parameter int unsigned KW       = kw_of(NumOuter),
  parameter int unsigned LW       = lw_of(NumOuter),
  parameter int unsigned PW       = pw_of(NumOuter)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [NumOuterWidth-1:0] num_outer_i,
  input  logic                     abort_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [KW-1:0]            k_o,
  output logic [LW-1:0]            l_o,
  output logic [PW-1:0]            param_o,
  output logic                     last_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef LOOP_NEST_SEQ_STATS_EN
  ,
  output logic [31:0]              stall_cnt_o
`endif
);

  localparam logic [NumOuterWidth-1:0] NumOuterMax = NumOuterWidth'(NumOuter);

  // Last inner index for a given outer index: 2^k - 1.
  function automatic logic [LW-1:0] l_max_of(input logic [KW-1:0] k);
    logic [PW-1:0] pow;
    pow = PW'(1) << k;
    return LW'(pow - PW'(1));
  endfunction

  state_e                     state_q, state_d;
  logic [NumOuterWidth-1:0]   n_q, n_d;
  logic [NumOuterWidth-1:0]   n_clamp;
  logic [KW-1:0]              k_d, k_step;
  logic [LW-1:0]              l_d, l_step;
  logic [PW-1:0]              param_d;
  logic                       last_d, valid_d, busy_d, done_d;
  logic                       handshake;
  logic                       start_acc;

  assign n_clamp   = (num_outer_i > NumOuterMax) ? NumOuterMax : num_outer_i;
  assign handshake = valid_o & ready_i;
  assign start_acc = (state_q == IDLE) & start_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = (n_clamp == '0) ? DONE : RUN;
      RUN: begin
        if (abort_i)                  state_d = IDLE;
        else if (handshake && last_o) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; payload is zeroed outside RUN.
  always_comb begin
    n_d = n_q;
    k_d = k_o;
    l_d = l_o;

    if (l_o == l_max_of(k_o)) begin
      k_step = k_o + KW'(1);
      l_step = '0;
    end else begin
      k_step = k_o;
      l_step = l_o + LW'(1);
    end

    if (start_acc) begin
      n_d = n_clamp;
      k_d = '0;
      l_d = '0;
    end else if ((state_q == RUN) && handshake) begin
      k_d = k_step;
      l_d = l_step;
    end

    if (state_d != RUN) begin
      k_d = '0;
      l_d = '0;
    end

    // l < 2^k, so OR-ing the leading one is an exact 2^k + l.
    param_d = (state_d == RUN) ? ((PW'(1) << k_d) | PW'(l_d)) : '0;
    last_d  = (state_d == RUN)
            && (NumOuterWidth'(k_d) == (n_d - NumOuterWidth'(1)))
            && (l_d == l_max_of(k_d));
    valid_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // Output and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q     <= '0;
      k_o     <= '0;
      l_o     <= '0;
      param_o <= '0;
      last_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      n_q     <= n_d;
      k_o     <= k_d;
      l_o     <= l_d;
      param_o <= param_d;
      last_o  <= last_d;
      valid_o <= valid_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

`ifdef LOOP_NEST_SEQ_STATS_EN
  // Saturating stall counter, cleared when a run starts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (start_acc) begin
      stall_cnt_o <= '0;
    end else if ((state_q == RUN) && !ready_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_loop_nest_sequencer.sv
module tb_loop_nest_sequencer;
  import loop_nest_seq_pkg::*;

  localparam int unsigned NUM = 3;
  localparam int unsigned KW  = kw_of(NUM);
  localparam int unsigned LW  = lw_of(NUM);
  localparam int unsigned PW  = pw_of(NUM);

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     start_i = 1'b0;
  logic [NumOuterWidth-1:0] num_outer_i = '0;
  logic                     abort_i = 1'b0;
  logic                     ready_i = 1'b0;
  logic                     valid_o;
  logic [KW-1:0]            k_o;
  logic [LW-1:0]            l_o;
  logic [PW-1:0]            param_o;
  logic                     last_o, busy_o, done_o;
`ifdef LOOP_NEST_SEQ_STATS_EN
  logic [31:0]              stall_cnt_o;
`endif

  loop_nest_sequencer #(.NumOuter(NUM)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .num_outer_i(num_outer_i),
    .abort_i    (abort_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .k_o        (k_o),
    .l_o        (l_o),
    .param_o    (param_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef LOOP_NEST_SEQ_STATS_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned k;
    int unsigned l;
    int unsigned p;
  } tup_t;

  // Model: the remaining tuples of the current run as a queue.
  tup_t        exp_q[$];
  bit          m_run;
  bit          m_done;
  int unsigned m_stall;

  int unsigned obs[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_step(input bit st, input int unsigned n, input bit ab,
                            input bit rd, input bit rs);
    int unsigned nn;
    if (rs) begin
      exp_q.delete();
      m_run   = 0;
      m_done  = 0;
      m_stall = 0;
      return;
    end
    if (m_run && !rd && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (rd) void'(exp_q.pop_front());
      if (ab) begin
        m_run = 0;
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        m_run  = 0;
        m_done = 1;
      end
    end else if (st) begin
      nn = (n > NUM) ? NUM : n;
      exp_q.delete();
      m_stall = 0;
      for (int unsigned k = 0; k < nn; k++)
        for (int unsigned l = 0; l < (1 << k); l++)
          exp_q.push_back('{k, l, (1 << k) + l});
      if (exp_q.size() == 0) m_done = 1;
      else m_run = 1;
    end
  endtask

  task automatic compare();
    chk("valid", 32'(valid_o), 32'(m_run));
    chk("busy", 32'(busy_o), 32'(m_run || m_done));
    chk("done", 32'(done_o), 32'(m_done));
    if (m_run) begin
      chk("k", 32'(k_o), exp_q[0].k);
      chk("l", 32'(l_o), exp_q[0].l);
      chk("param", 32'(param_o), exp_q[0].p);
      chk("last", 32'(last_o), 32'(exp_q.size() == 1));
    end else if (!m_done) begin
      chk("idle_payload", {k_o, l_o, param_o, last_o}, 32'd0);
    end
`ifdef LOOP_NEST_SEQ_STATS_EN
    chk("stall_cnt", stall_cnt_o, m_stall);
`endif
  endtask

  // One clock: drive inputs, record accepted params, step the model, compare.
  task automatic cyc(input bit st, input int unsigned n, input bit ab,
                     input bit rd, input bit rs);
    start_i     = st;
    num_outer_i = NumOuterWidth'(n);
    abort_i     = ab;
    ready_i     = rd;
    rst_i       = rs;
    if (valid_o && rd && !rs) obs.push_back(32'(param_o));
    @(posedge clk);
    #1;
    model_step(st, n, ab, rd, rs);
    compare();
  endtask

  task automatic idle(input int unsigned cycles);
    for (int i = 0; i < cycles; i++) cyc(0, 0, 0, 1, 0);
  endtask

  initial begin
    int unsigned n_r;
    #1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_param", 32'(param_o), 32'd0);
    idle(2);

    // Full run, n=3, always ready.
    obs.delete();
    cyc(1, 3, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("last_on_7th", 32'(last_o), 32'd1);
      else if (i == 5) chk("no_last_on_6th", 32'(last_o), 32'd0);
      cyc(0, 0, 0, 1, 0);
    end
    chk("done_after_last", 32'(done_o), 32'd1);
    chk("busy_in_done", 32'(busy_o), 32'd1);
    idle(1);
    chk("busy_drops", 32'(busy_o), 32'd0);
    chk("full_count", obs.size(), 32'd7);
    for (int i = 0; i < obs.size() && i < 7; i++) chk("full_param_seq", obs[i], 32'(i + 1));

    // Backpressure on (1,1,3).
    obs.delete();
    cyc(1, 3, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("bp_hold_param", 32'(param_o), 32'd3);
      chk("bp_hold_k", 32'(k_o), 32'd1);
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    chk("bp_count", obs.size(), 32'd7);
`ifdef LOOP_NEST_SEQ_STATS_EN
    chk("bp_stall_lit", stall_cnt_o, 32'd3);
`endif
    idle(2);

    // n=0: immediate done, no tuple.
    cyc(1, 0, 0, 1, 0);
    chk("n0_done", 32'(done_o), 32'd1);
    chk("n0_valid", 32'(valid_o), 32'd0);
    idle(2);

    // n=9 clamps to NumOuter.
    obs.delete();
    cyc(1, 9, 0, 1, 0);
    idle(10);
    chk("clamp_count", obs.size(), 32'd7);

    // n=2: last on (1,1,3).
    obs.delete();
    cyc(1, 2, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("n2_last_param", 32'(param_o), 32'd3);
    chk("n2_last", 32'(last_o), 32'd1);
    idle(4);
    chk("n2_count", obs.size(), 32'd3);

    // Abort on (2,1,5) with ready, then restart.
    obs.delete();
    cyc(1, 3, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    chk("abort_at_param", 32'(param_o), 32'd5);
    cyc(0, 0, 1, 1, 0);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_no_done", 32'(done_o), 32'd0);
    chk("abort_count", obs.size(), 32'd5);
    cyc(1, 3, 0, 0, 0);
    chk("restart_param", 32'(param_o), 32'd1);
    idle(10);

    // Reset during (2,0,4); start during RUN is ignored.
    cyc(1, 3, 0, 1, 0);
    cyc(1, 2, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("pre_rst_param", 32'(param_o), 32'd4);
    cyc(0, 0, 0, 1, 1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_param", 32'(param_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    idle(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      n_r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      cyc(($urandom_range(0, 5) == 0), n_r, ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
